wishbone_arbiter: RTL and testbench



---
 rtl/wishbone_arbiter_pkg.sv | 15 +
 rtl/wishbone_arbiter_if.sv | 35 +++
 rtl/wishbone_arbiter_watchdog.sv | 32 +++
 rtl/wishbone_arbiter.sv | 111 +++++++++++
 tb/tb_wishbone_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/wishbone_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wishbone_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // Counter width able to hold TIMEOUT; a disabled watchdog still gets one bit.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/wishbone_arbiter_if.sv
// Wishbone B3 bus bundle; master modport drives the request, slave modport the response.
interface wishbone_arbiter_if #(
  parameter int TGC_WIDTH = 3,
  parameter int TGA_WIDTH = 2,
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32
);
  localparam int SEL_WIDTH = DAT_WIDTH / 8;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic                 lock;
  logic [ADR_WIDTH-1:0] adr;
  logic [DAT_WIDTH-1:0] dat_w;
  logic [DAT_WIDTH-1:0] dat_r;
  logic [SEL_WIDTH-1:0] sel;
  logic [2:0]           cti;
  logic [1:0]           bte;
  logic [TGC_WIDTH-1:0] tgc;
  logic [TGA_WIDTH-1:0] tga;
  logic                 ack;
  logic                 err;
  logic                 rty;

  modport master (
    output cyc, stb, we, lock, adr, dat_w, sel, cti, bte, tgc, tga,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, lock, adr, dat_w, sel, cti, bte, tgc, tga,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wishbone_arbiter_watchdog.sv
// Stall watchdog: counts unterminated strobe cycles, fires once at TIMEOUT (0 disables).
module wb_watchdog
  import wishbone_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic active,
  output logic expire
);
  localparam int            CW = cnt_width(TIMEOUT);
  localparam bit            EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] TC = EN ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT-th stalled cycle, so the terminating err lands on it.
  assign expire = EN && active && !clear && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expire || !EN) cnt_d = '0;
    else if (active)            cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin, per-cycle arbiter letting two Wishbone masters share one slave.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter int TGC_WIDTH = 3,
  parameter int TGA_WIDTH = 2,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  wishbone_arbiter_if.slave  m0,
  wishbone_arbiter_if.slave  m1,
  wishbone_arbiter_if.master s,
  output logic [1:0]         grant,
  output logic               timeout
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_GNT0 = GNT0;
  localparam logic [1:0] ST_GNT1 = GNT1;

  logic [1:0]           state_q, state_d;
  logic                 last_q, last_d;
  logic                 own0, own1, gstb, term, enter, expire;
  logic [TGC_WIDTH-1:0] tgc_mux;
  logic [TGA_WIDTH-1:0] tga_mux;

  assign own0  = (state_q == ST_GNT0);
  assign own1  = (state_q == ST_GNT1);
  assign gstb  = (own0 & m0.stb) | (own1 & m1.stb);
  assign term  = (own0 | own1) & (s.ack | s.err | s.rty);
  assign enter = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0.cyc && (!m1.cyc || last_q)) state_d = ST_GNT0;
        else if (m1.cyc)                   state_d = ST_GNT1;
      end
      ST_GNT0: if (!m0.cyc) state_d = m1.cyc ? ST_GNT1 : ST_IDLE;
      ST_GNT1: if (!m1.cyc) state_d = m0.cyc ? ST_GNT0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (enter && state_d == ST_GNT0) last_d = 1'b0;
    if (enter && state_d == ST_GNT1) last_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (enter | term | ~gstb),
    .active (gstb & ~term),
    .expire (expire)
  );

  assign grant = {own1, own0};
  // Decoded from the registered count, qualified so a same-cycle slave ack wins.
  assign timeout = expire;

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.lock   = 1'b0;
    s.adr    = '0;
    s.dat_w  = '0;
    s.sel    = '0;
    s.cti    = '0;
    s.bte    = '0;
    tgc_mux  = '0;
    tga_mux  = '0;
    m0.dat_r = '0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.rty   = 1'b0;
    m1.dat_r = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.rty   = 1'b0;
    if (own0) begin
      s.cyc = m0.cyc;  s.stb = m0.stb;  s.we  = m0.we;   s.lock = m0.lock;
      s.adr = m0.adr;  s.dat_w = m0.dat_w; s.sel = m0.sel; s.cti = m0.cti;
      s.bte = m0.bte;  tgc_mux = m0.tgc; tga_mux = m0.tga;
      m0.dat_r = s.dat_r; m0.ack = s.ack; m0.err = s.err | expire; m0.rty = s.rty;
    end else if (own1) begin
      s.cyc = m1.cyc;  s.stb = m1.stb;  s.we  = m1.we;   s.lock = m1.lock;
      s.adr = m1.adr;  s.dat_w = m1.dat_w; s.sel = m1.sel; s.cti = m1.cti;
      s.bte = m1.bte;  tgc_mux = m1.tgc; tga_mux = m1.tga;
      m1.dat_r = s.dat_r; m1.ack = s.ack; m1.err = s.err | expire; m1.rty = s.rty;
    end
    // Abort the stalled slave access for the expiry cycle only; grant is kept.
    if (expire) begin
      s.cyc = 1'b0;
      s.stb = 1'b0;
    end
  end

  assign s.tgc = tgc_mux;
  assign s.tga = tga_mux;
endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences for reset and disabled watchdog.
module tb_wishbone_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wishbone_arbiter_if #(.TGC_WIDTH(3), .TGA_WIDTH(2)) a_m0(), a_m1(), a_s();
  wishbone_arbiter_if #(.TGC_WIDTH(3), .TGA_WIDTH(2)) b_m0(), b_m1(), b_s();
  logic [1:0] a_grant, b_grant;
  logic       a_to, b_to;

  wishbone_arbiter #(.TGC_WIDTH(3), .TGA_WIDTH(2), .TIMEOUT(4)) dut_a (
    .clock(clk), .reset(rst), .m0(a_m0), .m1(a_m1), .s(a_s),
    .grant(a_grant), .timeout(a_to));

  wishbone_arbiter #(.TGC_WIDTH(3), .TGA_WIDTH(2), .TIMEOUT(0)) dut_b (
    .clock(clk), .reset(rst), .m0(b_m0), .m1(b_m1), .s(b_s),
    .grant(b_grant), .timeout(b_to));

  typedef struct packed {
    logic c0, s0, c1, s1, ack;
    logic [1:0] g;
    logic scyc, sstb, a0, a1, e0, to;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [4:0] in, input logic [1:0] g, input logic [5:0] out);
    return vec_t'({in, g, out});
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    int bad;
    logic [31:0] e_adr;

    // in = {m0.cyc, m0.stb, m1.cyc, m1.stb, s.ack}; out = {s.cyc, s.stb, m0.ack, m1.ack, m0.err, timeout}
    tv.push_back(mk(5'b00000, 2'b00, 6'b000000)); // idle after reset
    tv.push_back(mk(5'b11110, 2'b00, 6'b000000)); // simultaneous request, 1-cycle latency
    tv.push_back(mk(5'b11111, 2'b01, 6'b111000)); // m0 wins first contention
    tv.push_back(mk(5'b00110, 2'b01, 6'b000000)); // m0 drops cyc
    tv.push_back(mk(5'b00111, 2'b10, 6'b110100)); // m1 granted with no idle gap
    tv.push_back(mk(5'b00000, 2'b10, 6'b000000));
    tv.push_back(mk(5'b11110, 2'b00, 6'b000000)); // second contention
    tv.push_back(mk(5'b11111, 2'b01, 6'b111000)); // m0 again (last = 1)
    tv.push_back(mk(5'b00110, 2'b01, 6'b000000));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(5'b11111, 2'b10, 6'b110100)); // m1 burst beats, m0 waiting
    tv.push_back(mk(5'b11000, 2'b10, 6'b000000)); // m1 ends burst
    tv.push_back(mk(5'b11001, 2'b01, 6'b111000)); // m0 single read
    tv.push_back(mk(5'b00000, 2'b01, 6'b000000));
    tv.push_back(mk(5'b00000, 2'b00, 6'b000000));
    tv.push_back(mk(5'b11000, 2'b00, 6'b000000)); // m0 write, slave never acks
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(5'b11000, 2'b01, 6'b110000));
    tv.push_back(mk(5'b11000, 2'b01, 6'b000011)); // 4th stalled cycle: err + timeout
    tv.push_back(mk(5'b00000, 2'b01, 6'b000000));
    tv.push_back(mk(5'b00000, 2'b00, 6'b000000));
    tv.push_back(mk(5'b11000, 2'b00, 6'b000000));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(5'b11000, 2'b01, 6'b110000));
    tv.push_back(mk(5'b11001, 2'b01, 6'b111000)); // ack on expiry cycle wins
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(5'b11000, 2'b01, 6'b110000));
    tv.push_back(mk(5'b10000, 2'b01, 6'b100000)); // stb low clears the count
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(5'b11000, 2'b01, 6'b110000));
    tv.push_back(mk(5'b11000, 2'b01, 6'b000011));
    tv.push_back(mk(5'b00000, 2'b01, 6'b000000));
    tv.push_back(mk(5'b00000, 2'b00, 6'b000000));

    a_m0.cyc = 1'b1; a_m0.stb = 1'b1; a_m0.we = 1'b1; a_m0.lock = 1'b0;
    a_m0.adr = 32'h0000_0100; a_m0.dat_w = 32'h1111_1111; a_m0.sel = 4'hF;
    a_m0.cti = 3'b000; a_m0.bte = 2'b00; a_m0.tgc = 3'd1; a_m0.tga = 2'd1;
    a_m1.cyc = 1'b0; a_m1.stb = 1'b0; a_m1.we = 1'b0; a_m1.lock = 1'b0;
    a_m1.adr = 32'h0000_0200; a_m1.dat_w = 32'h2222_2222; a_m1.sel = 4'hF;
    a_m1.cti = 3'b010; a_m1.bte = 2'b00; a_m1.tgc = 3'd2; a_m1.tga = 2'd2;
    a_s.dat_r = 32'hDEAD_BEEF; a_s.ack = 1'b1; a_s.err = 1'b0; a_s.rty = 1'b0;
    b_m0.cyc = 1'b0; b_m0.stb = 1'b0; b_m0.we = 1'b1; b_m0.lock = 1'b0;
    b_m0.adr = 32'h0000_0100; b_m0.dat_w = '0; b_m0.sel = 4'hF;
    b_m0.cti = 3'b000; b_m0.bte = 2'b00; b_m0.tgc = '0; b_m0.tga = '0;
    b_m1.cyc = 1'b0; b_m1.stb = 1'b0; b_m1.we = 1'b0; b_m1.lock = 1'b0;
    b_m1.adr = '0; b_m1.dat_w = '0; b_m1.sel = '0;
    b_m1.cti = '0; b_m1.bte = '0; b_m1.tgc = '0; b_m1.tga = '0;
    b_s.dat_r = '0; b_s.ack = 1'b0; b_s.err = 1'b0; b_s.rty = 1'b0;

    // Held in reset with m0 requesting and slave acking: nothing may pass.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", -1, 32'(a_grant), 32'd0);
    chk("rst_scyc",  -1, 32'(a_s.cyc), 32'd0);
    chk("rst_m0ack", -1, 32'(a_m0.ack), 32'd0);
    chk("rst_to",    -1, 32'(a_to), 32'd0);
    a_m0.cyc = 1'b0; a_m0.stb = 1'b0; a_s.ack = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      a_m0.cyc = tv[i].c0; a_m0.stb = tv[i].s0;
      a_m1.cyc = tv[i].c1; a_m1.stb = tv[i].s1;
      a_s.ack  = tv[i].ack;
      #1;
      e_adr = tv[i].g[0] ? 32'h100 : (tv[i].g[1] ? 32'h200 : 32'h0);
      chk("grant",   i, 32'(a_grant),  32'(tv[i].g));
      chk("s_cyc",   i, 32'(a_s.cyc),  32'(tv[i].scyc));
      chk("s_stb",   i, 32'(a_s.stb),  32'(tv[i].sstb));
      chk("m0_ack",  i, 32'(a_m0.ack), 32'(tv[i].a0));
      chk("m1_ack",  i, 32'(a_m1.ack), 32'(tv[i].a1));
      chk("m0_err",  i, 32'(a_m0.err), 32'(tv[i].e0));
      chk("m1_err",  i, 32'(a_m1.err), 32'd0);
      chk("timeout", i, 32'(a_to),     32'(tv[i].to));
      chk("s_adr",   i, a_s.adr,       e_adr);
      chk("s_we",    i, 32'(a_s.we),   32'(tv[i].g[0]));
      chk("s_cti",   i, 32'(a_s.cti),  tv[i].g[1] ? 32'd2 : 32'd0);
      chk("m0_dat",  i, a_m0.dat_r,    tv[i].g[0] ? 32'hDEAD_BEEF : 32'h0);
      chk("m1_dat",  i, a_m1.dat_r,    tv[i].g[1] ? 32'hDEAD_BEEF : 32'h0);
    end

    // Asynchronous reset in the middle of an m1 burst.
    @(negedge clk);
    a_m1.cyc = 1'b1; a_m1.stb = 1'b1; a_s.ack = 1'b0;
    @(negedge clk);
    a_s.ack = 1'b1;
    #1;
    chk("arst_pre_grant", -1, 32'(a_grant), 32'd2);
    chk("arst_pre_scyc",  -1, 32'(a_s.cyc), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_grant", -1, 32'(a_grant),  32'd0);
    chk("arst_scyc",  -1, 32'(a_s.cyc),  32'd0);
    chk("arst_sstb",  -1, 32'(a_s.stb),  32'd0);
    chk("arst_m1ack", -1, 32'(a_m1.ack), 32'd0);
    @(negedge clk);
    rst = 1'b0; a_s.ack = 1'b0;
    a_m0.cyc = 1'b1; a_m0.stb = 1'b1;
    #1;
    chk("post_rst_idle", -1, 32'(a_grant), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_grant", -1, 32'(a_grant), 32'd1);
    @(negedge clk);
    a_m0.cyc = 1'b0; a_m0.stb = 1'b0; a_m1.cyc = 1'b0; a_m1.stb = 1'b0;

    // Disabled watchdog: a 1000-cycle stall must never be aborted.
    @(negedge clk);
    b_m0.cyc = 1'b1; b_m0.stb = 1'b1;
    @(negedge clk);
    #1;
    chk("nowd_grant0", -1, 32'(b_grant), 32'd1);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      #1;
      if (b_m0.err !== 1'b0 || b_to !== 1'b0 || b_grant !== 2'b01 || b_s.stb !== 1'b1) bad++;
    end
    chk("nowd_bad_cycles", -1, 32'(bad), 32'd0);
    chk("nowd_grant_end", -1, 32'(b_grant), 32'd1);
    b_m0.cyc = 1'b0; b_m0.stb = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
